l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
- Initiator side of the L2 line interface; arbitrates between the I-cache and D-cache miss ports.
- Issues one line-sized read or write at a time to the L2 cache and holds it until the L2 returns mem_resp.
- Routes the response and read data back to the requesting L1 only.
- Sits between the two L1 caches and cacheL2, ahead of physical memory.

Parameters:
- ADDR_WIDTH, 16, line address width (lc3b_word).
- LINE_WIDTH, 128, cache line width (cache_line).
- MASK_WIDTH, 2, byte-enable width (lc3b_mem_wmask).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- icache_read  in  1  I-cache line read request, held until icache_resp
- icache_address  in  ADDR_WIDTH  I-cache line address
- icache_rdata  out  LINE_WIDTH  line returned to I-cache
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_read  in  1  D-cache line read request, held until dcache_resp
- dcache_write  in  1  D-cache line write-back request, held until dcache_resp
- dcache_address  in  ADDR_WIDTH  D-cache line address
- dcache_wdata  in  LINE_WIDTH  write-back line
- dcache_rdata  out  LINE_WIDTH  line returned to D-cache
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- l2_mem_address  out  ADDR_WIDTH  latched address to L2
- l2_mem_wdata  out  LINE_WIDTH  latched write line to L2
- l2_mem_read  out  1  L2 read request
- l2_mem_write  out  1  L2 write request
- l2_mem_byte_enable  out  MASK_WIDTH  always all ones (full-line transfers)
- l2_mem_rdata  in  LINE_WIDTH  L2 read data, valid with l2_mem_resp
- l2_mem_resp  in  1  L2 completion

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset (reset_n=0 at a clock edge) forces:
  - state to IDLE;
  - l2_mem_read/l2_mem_write/icache_resp/dcache_resp to 0;
  - l2_mem_address, l2_mem_wdata and last_grant to 0.
- IDLE behaviour:
  - If any request is pending, latch address (and dcache_wdata for a write) into output registers and move to the granted SERVE state.
  - Set the latched op bits so that l2_mem_read or l2_mem_write rises exactly 1 cycle after the request was first seen.
- Simultaneous I and D requests in IDLE: D-cache wins (fixed priority) unless the optional feature is enabled.
- dcache_read and dcache_write both high: treated as a write; the read is dropped for that grant.
- SERVE_x behaviour:
  - Hold l2_mem_* outputs stable.
  - On the cycle l2_mem_resp=1:
    - the matching x_resp=1 combinationally in the same cycle;
    - x_rdata = l2_mem_rdata passed through;
    - the op bits clear at the next edge;
    - the FSM returns to IDLE.
- One IDLE cycle always separates grants, so a requester that drops its request after resp is never re-granted.
- The non-granted L1's resp is 0 throughout. Its rdata output is don't-care and is driven with l2_mem_rdata.
- l2_mem_resp while in IDLE is ignored. This covers a stale response after a reset mid-transaction.
- Reset mid-SERVE aborts the transaction. No resp is issued and the L1 must re-request.
- A request change during SERVE has no effect; latched values are used.
- Minimum round trip: request at cycle 0, L2 request at cycle 1, resp at cycle 1+L2 latency.

Optional Feature:
- Macro: L2_ARB_ROUND_ROBIN_EN.
- When defined: a 1-bit last_grant register (0=I, 1=D) is updated on each grant. On simultaneous requests in IDLE, the port not granted last wins.
- When undefined: fixed D-cache priority, and last_grant is absent.
- Both modes behave identically when only one port requests.

Decomposition:
- Shared package (cache_types): cache_line, the arb_state_t enum {IDLE, SERVE_I, SERVE_D}, and the constant FULL_WMASK = all ones.
- Address width comes from lc3b_types::lc3b_word.
- No sub-module. Single module: FSM plus latch registers.

Test Plan:
- I-only read of 0x1230; L2 responds after 3 cycles with line A -> l2_mem_read high cycles 1..4, icache_resp pulse at cycle 4, icache_rdata=A, dcache_resp=0.
- D write-back of 0x4560 with line B -> l2_mem_write=1, l2_mem_wdata=B, byte_enable=2'b11; dcache_resp single pulse; then IDLE one cycle.
- I read and D read asserted same cycle (macro off) -> D served first, I served after one IDLE gap; two grants total.
- Same with L2_ARB_ROUND_ROBIN_EN defined and last grant D -> I served first. Repeat the simultaneous request -> D wins.
- reset_n=0 during SERVE_D, then l2_mem_resp=1 arrives in IDLE -> no dcache_resp/icache_resp; outputs zero; next request proceeds normally.
- dcache_address changes to 0x7770 mid-SERVE -> l2_mem_address stays at the latched 0x4560 until the response.

Source files
------------

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 line arbiter: word/line types, FSM state encoding
// and the full-line byte-enable constant.
package l2_arbiter_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int LINE_WIDTH = 128;
  localparam int MASK_WIDTH = 2;

  typedef logic [ADDR_WIDTH-1:0] lc3b_word;
  typedef logic [LINE_WIDTH-1:0] cache_line;
  typedef logic [MASK_WIDTH-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam lc3b_mem_wmask FULL_WMASK = '1;

endpackage

// File: rtl/l2_arbiter_if.sv
// L1/L2 line-transfer bundle. The arbiter uses the master view (it drives the
// L2 request and the L1 responses); the slave view belongs to the L1s and L2.
interface l2_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int MASK_WIDTH = 2
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic [ADDR_WIDTH-1:0] l2_mem_address;
  logic [LINE_WIDTH-1:0] l2_mem_wdata;
  logic                  l2_mem_read;
  logic                  l2_mem_write;
  logic [MASK_WIDTH-1:0] l2_mem_byte_enable;
  logic [LINE_WIDTH-1:0] l2_mem_rdata;
  logic                  l2_mem_resp;

  modport master (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output l2_mem_address, l2_mem_wdata, l2_mem_read, l2_mem_write, l2_mem_byte_enable,
    input  l2_mem_rdata, l2_mem_resp
  );

  modport slave (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  l2_mem_address, l2_mem_wdata, l2_mem_read, l2_mem_write, l2_mem_byte_enable,
    output l2_mem_rdata, l2_mem_resp
  );
endinterface

// File: rtl/l2_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto the single L2 port, one
// transaction at a time. Define L2_ARB_ROUND_ROBIN_EN for round-robin on ties.
module l2_arbiter
  import l2_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  l2_arbiter_if.master bus
);

  arb_state_t state;
  lc3b_word   mem_address;
  cache_line  mem_wdata;
  logic       mem_read;
  logic       mem_write;
  logic       i_req;
  logic       d_req;
  logic       grant_d;

`ifdef L2_ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  always_comb begin
    i_req = bus.icache_read;
    d_req = bus.dcache_read | bus.dcache_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time goes first (1 = D last).
    grant_d = d_req && (!i_req || !last_grant);
`else
    grant_d = d_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_grant <= grant_d;
`endif
            if (grant_d) begin
              state       <= SERVE_D;
              mem_address <= bus.dcache_address;
              // A simultaneous read+write is served as the write-back only.
              mem_read    <= !bus.dcache_write;
              mem_write   <= bus.dcache_write;
              if (bus.dcache_write)
                mem_wdata <= bus.dcache_wdata;
            end else begin
              state       <= SERVE_I;
              mem_address <= bus.icache_address;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.l2_mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l2_mem_address     = mem_address;
  assign bus.l2_mem_wdata       = mem_wdata;
  assign bus.l2_mem_read        = mem_read;
  assign bus.l2_mem_write       = mem_write;
  assign bus.l2_mem_byte_enable = FULL_WMASK;

  // Responses are gated by the owning state, so a stale resp in IDLE is dropped.
  assign bus.icache_resp  = (state == SERVE_I) && bus.l2_mem_resp;
  assign bus.dcache_resp  = (state == SERVE_D) && bus.l2_mem_resp;
  assign bus.icache_rdata = bus.l2_mem_rdata;
  assign bus.dcache_rdata = bus.l2_mem_rdata;

endmodule
